// File: rtl/kv_fpu_wb_buf.sv
`default_nettype none
// ============================================================================
// Module      : kv_fpu_wb_buf
// Description : Writeback buffer for FPU move/sign-inject results. A small
//               FIFO that formats each result at push time and presents it
//               to the register file. The formatting applies NaN-boxing for
//               FP destinations and sign-extension for integer destinations.
//               Optional macro KV_FPU_WB_BYPASS_EN lets an empty buffer
//               forward the formatted input to wb_* in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module kv_fpu_wb_buf #(
    parameter int FLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic        core_clk,
    input  logic        core_reset,
    input  logic        f1_valid,
    output logic        f1_ready,
    input  logic [63:0] f1_wdata,
    input  logic [2:0]  f1_sew,
    input  logic [4:0]  f1_rd,
    input  logic        f1_fpr,
    input  logic        fpu_flush,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [63:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_fpr,
    output logic        wb_standby_ready
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [63:0]        r_data [DEPTH];
    logic [4:0]         r_rd   [DEPTH];
    logic               r_fpr  [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic [63:0] w_fmt;
    logic        w_byp;
    logic        w_push;
    logic        w_pop;
    logic        w_fifo_valid;

    // Result formatting: NaN-box FP results, sign-extend integer results
    always_comb begin
        w_fmt = f1_wdata;
        if (f1_fpr) begin
            if (f1_sew[2]) begin
                w_fmt = f1_wdata;
            end else if (f1_sew[1]) begin
                w_fmt = {32'hffff_ffff, f1_wdata[31:0]};
            end else if (f1_sew[0]) begin
                w_fmt = {48'hffff_ffff_ffff, f1_wdata[15:0]};
            end
            // A 32-bit FP register file holds no upper half; 16-bit values
            // are boxed only within the low word.
            if (FLEN == 32) begin
                w_fmt[63:32] = 32'h0;
            end
        end else begin
            if (f1_sew[2]) begin
                w_fmt = f1_wdata;
            end else if (f1_sew[1]) begin
                w_fmt = {{32{f1_wdata[31]}}, f1_wdata[31:0]};
            end else if (f1_sew[0]) begin
                w_fmt = {{48{f1_wdata[15]}}, f1_wdata[15:0]};
            end
        end
    end

    // Handshake, bypass selection and head-entry output muxing
    always_comb begin
`ifdef KV_FPU_WB_BYPASS_EN
        w_byp = (r_count == '0) & f1_valid & ~fpu_flush;
`else
        w_byp = 1'b0;
`endif
        w_fifo_valid     = (r_count != '0) & ~fpu_flush;
        f1_ready         = (r_count < c_FULL) & ~fpu_flush;
        wb_valid         = w_fifo_valid | w_byp;
        // A bypassed result consumed immediately never occupies an entry.
        w_push           = f1_valid & f1_ready & ~(w_byp & wb_ready);
        w_pop            = w_fifo_valid & wb_ready;
        wb_standby_ready = (r_count == '0) & ~f1_valid;
        if (w_byp) begin
            wb_data = w_fmt;
            wb_rd   = f1_rd;
            wb_fpr  = f1_fpr;
        end else begin
            wb_data = r_data[r_rptr];
            wb_rd   = r_rd[r_rptr];
            wb_fpr  = r_fpr[r_rptr];
        end
    end

    // Pointer and occupancy tracking; flush overrides any push or pop
    always_ff @(posedge core_clk or posedge core_reset) begin
        if (core_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (fpu_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage, cleared on reset so the idle head reads as zero
    always_ff @(posedge core_clk or posedge core_reset) begin
        if (core_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_rd[i]   <= '0;
                r_fpr[i]  <= 1'b0;
            end
        end else if (w_push && !fpu_flush) begin
            r_data[r_wptr] <= w_fmt;
            r_rd[r_wptr]   <= f1_rd;
            r_fpr[r_wptr]  <= f1_fpr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kv_fpu_wb_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_kv_fpu_wb_buf
// Description : Self-checking bench for kv_fpu_wb_buf (FLEN=64, DEPTH=2).
//               Formatting vectors come from a table; FIFO fill, flush and
//               reset behaviour are exercised by hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kv_fpu_wb_buf;

    logic        clk;
    logic        rst;
    logic        f1_valid;
    logic        f1_ready;
    logic [63:0] f1_wdata;
    logic [2:0]  f1_sew;
    logic [4:0]  f1_rd;
    logic        f1_fpr;
    logic        fpu_flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_fpr;
    logic        wb_standby_ready;

    int n_pass;
    int n_total;

    kv_fpu_wb_buf #(.FLEN(64), .DEPTH(2)) dut (
        .core_clk         (clk),
        .core_reset       (rst),
        .f1_valid         (f1_valid),
        .f1_ready         (f1_ready),
        .f1_wdata         (f1_wdata),
        .f1_sew           (f1_sew),
        .f1_rd            (f1_rd),
        .f1_fpr           (f1_fpr),
        .fpu_flush        (fpu_flush),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_data          (wb_data),
        .wb_rd            (wb_rd),
        .wb_fpr           (wb_fpr),
        .wb_standby_ready (wb_standby_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fpr;
        logic [2:0]  sew;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        f1_valid  = 1'b0;
        f1_wdata  = '0;
        f1_sew    = 3'b100;
        f1_rd     = '0;
        f1_fpr    = 1'b0;
        fpu_flush = 1'b0;
        wb_ready  = 1'b0;

        vecs[0] = '{1'b1, 3'b010, 64'h0000_0000_3f80_0000, 64'hffff_ffff_3f80_0000};
        vecs[1] = '{1'b0, 3'b001, 64'h0000_0000_0000_8001, 64'hffff_ffff_ffff_8001};
        vecs[2] = '{1'b0, 3'b001, 64'h0000_0000_0000_7001, 64'h0000_0000_0000_7001};
        vecs[3] = '{1'b1, 3'b001, 64'h1234_5678_9abc_def0, 64'hffff_ffff_ffff_def0};
        vecs[4] = '{1'b0, 3'b010, 64'h1234_5678_8000_0001, 64'hffff_ffff_8000_0001};
        vecs[5] = '{1'b0, 3'b010, 64'hffff_ffff_7fff_ffff, 64'h0000_0000_7fff_ffff};
        vecs[6] = '{1'b1, 3'b100, 64'h0123_4567_89ab_cdef, 64'h0123_4567_89ab_cdef};
        vecs[7] = '{1'b0, 3'b100, 64'hdead_beef_0000_0001, 64'hdead_beef_0000_0001};

        // Reset state
        #2;
        chk("rst_wb_valid", {63'b0, wb_valid}, 64'd0);
        chk("rst_f1_ready", {63'b0, f1_ready}, 64'd1);
        chk("rst_standby",  {63'b0, wb_standby_ready}, 64'd1);
        chk("rst_wb_data",  wb_data, 64'd0);
        chk("rst_wb_rd",    {59'b0, wb_rd}, 64'd0);
        chk("rst_wb_fpr",   {63'b0, wb_fpr}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Formatting table: push with wb_ready low, then pop from the FIFO
        for (int i = 0; i < 8; i++) begin
            f1_valid = 1'b1;
            f1_fpr   = vecs[i].fpr;
            f1_sew   = vecs[i].sew;
            f1_wdata = vecs[i].wdata;
            f1_rd    = 5'(i + 1);
            wb_ready = 1'b0;
            tick();
            f1_valid = 1'b0;
            wb_ready = 1'b1;
            #1;
            chk($sformatf("vec%0d_valid", i), {63'b0, wb_valid}, 64'd1);
            chk($sformatf("vec%0d_data", i),  wb_data, vecs[i].exp);
            chk($sformatf("vec%0d_rd", i),    {59'b0, wb_rd}, 64'(i + 1));
            chk($sformatf("vec%0d_fpr", i),   {63'b0, wb_fpr}, {63'b0, vecs[i].fpr});
            tick();
            chk($sformatf("vec%0d_empty", i), {63'b0, wb_valid}, 64'd0);
        end

        // Fill to DEPTH with writeback stalled, third result held
        wb_ready = 1'b0;
        f1_sew   = 3'b100;
        f1_fpr   = 1'b1;
        f1_valid = 1'b1;
        f1_rd    = 5'd1;
        f1_wdata = 64'h1111_1111_1111_1111;
        tick();
        f1_rd    = 5'd2;
        f1_wdata = 64'h2222_2222_2222_2222;
        tick();
        f1_rd    = 5'd3;
        f1_wdata = 64'h3333_3333_3333_3333;
        #1;
        chk("full_f1_ready", {63'b0, f1_ready}, 64'd0);
        chk("full_standby",  {63'b0, wb_standby_ready}, 64'd0);
        chk("full_wb_rd",    {59'b0, wb_rd}, 64'd1);
        tick();
        chk("stall_wb_rd",   {59'b0, wb_rd}, 64'd1);
        chk("stall_wb_data", wb_data, 64'h1111_1111_1111_1111);
        chk("stall_ready",   {63'b0, f1_ready}, 64'd0);
        wb_ready = 1'b1;
        #1;
        chk("drain1_rd",     {59'b0, wb_rd}, 64'd1);
        chk("drain1_ready",  {63'b0, f1_ready}, 64'd0);
        tick();
        chk("drain2_rd",     {59'b0, wb_rd}, 64'd2);
        chk("drain2_ready",  {63'b0, f1_ready}, 64'd1);
        tick();
        f1_valid = 1'b0;
        chk("drain3_valid",  {63'b0, wb_valid}, 64'd1);
        chk("drain3_rd",     {59'b0, wb_rd}, 64'd3);
        chk("drain3_data",   wb_data, 64'h3333_3333_3333_3333);
        tick();
        chk("drained_valid", {63'b0, wb_valid}, 64'd0);
        chk("drained_stby",  {63'b0, wb_standby_ready}, 64'd1);

        // Flush with two entries buffered and a push offered
        wb_ready = 1'b0;
        f1_valid = 1'b1;
        f1_rd    = 5'd4;
        tick();
        f1_rd    = 5'd5;
        tick();
        f1_rd     = 5'd6;
        fpu_flush = 1'b1;
        #1;
        chk("flush_f1_ready", {63'b0, f1_ready}, 64'd0);
        chk("flush_wb_valid", {63'b0, wb_valid}, 64'd0);
        tick();
        fpu_flush = 1'b0;
        f1_valid  = 1'b0;
        #1;
        chk("postflush_valid", {63'b0, wb_valid}, 64'd0);
        chk("postflush_stby",  {63'b0, wb_standby_ready}, 64'd1);
        chk("postflush_ready", {63'b0, f1_ready}, 64'd1);
        f1_valid = 1'b1;
        f1_rd    = 5'd9;
        f1_wdata = 64'h9999_0000_0000_9999;
        tick();
        f1_valid = 1'b0;
        #1;
        chk("refill_rd",    {59'b0, wb_rd}, 64'd9);
        chk("refill_data",  wb_data, 64'h9999_0000_0000_9999);

        // Reset asserted mid-operation with one entry buffered
        chk("prerst_valid", {63'b0, wb_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", {63'b0, wb_valid}, 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("relrst_stby",  {63'b0, wb_standby_ready}, 64'd1);
        wb_ready = 1'b1;
        tick();
        chk("relrst_valid", {63'b0, wb_valid}, 64'd0);
        tick();
        chk("relrst_valid2", {63'b0, wb_valid}, 64'd0);

`ifdef KV_FPU_WB_BYPASS_EN
        // Same-cycle forwarding from an empty buffer
        f1_valid = 1'b1;
        f1_rd    = 5'd5;
        f1_fpr   = 1'b0;
        f1_sew   = 3'b001;
        f1_wdata = 64'h0000_0000_0000_8001;
        #1;
        chk("byp_valid", {63'b0, wb_valid}, 64'd1);
        chk("byp_rd",    {59'b0, wb_rd}, 64'd5);
        chk("byp_data",  wb_data, 64'hffff_ffff_ffff_8001);
        tick();
        f1_valid = 1'b0;
        #1;
        chk("byp_empty", {63'b0, wb_valid}, 64'd0);
        chk("byp_stby",  {63'b0, wb_standby_ready}, 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
